// File: rtl/riscv_pipeline_pkg.sv
// Shared pipeline definitions for the RISC-V core: architectural width,
// the canonical NOP, the default boot PC and the IF/ID bundle that fetch
// produces and decode consumes.
package riscv_pipeline_pkg;

    // Architectural register / instruction width; the IF/ID bundle is sized by it.
    localparam int XLEN = 32;

    // addi x0, x0, 0 -- loaded into IF/ID whenever it carries no real instruction.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Boot address used when the fetch stage is not given an explicit RESET_PC.
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    // Empty IF/ID slot: used both as the reset value and as the flush value.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc       = {XLEN{1'b0}};
        b.pc_plus4 = {XLEN{1'b0}};
        b.instr    = NOP_INSTR;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Resolves reset > flush > stall > load on every
// rising edge; with none of them asserted the contents simply hold.
module if_id_register
    import riscv_pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t ifid_r;
    if_id_t ifid_next_s;

    // Select the next IF/ID contents; flush beats stall because the
    // redirecting instruction is older than whatever is being held.
    always_comb begin
        ifid_next_s = ifid_r;
        if (flush) begin
            ifid_next_s = if_id_bubble();
        end else if (stall) begin
            ifid_next_s = ifid_r;
        end else if (load) begin
            ifid_next_s = d;
        end else begin
            ifid_next_s = ifid_r;
        end
    end

    // IF/ID state register with synchronous reset to an empty slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_r <= if_id_bubble();
        end else begin
            ifid_r <= ifid_next_s;
        end
    end

    assign q = ifid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, +4 adder and
// the IF/ID register feeding decode. Redirects from EX flush IF/ID and
// retarget the PC (word aligned); hazard stalls freeze PC and IF/ID.
// Optional performance counters are built only when FETCH_PERF_EN is
// defined; otherwise Fetch_count_o and Bubble_count_o are tied to zero.
// DATA_WIDTH must equal riscv_pipeline_pkg::XLEN since the IF/ID bundle is
// shared with decode.
module fetch_stage
    import riscv_pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Redirect_target_i,
    output logic [DATA_WIDTH-1:0] Imem_addr_o,
    input  logic [DATA_WIDTH-1:0] Imem_instr_i,
    output logic [DATA_WIDTH-1:0] IFID_pc_o,
    output logic [DATA_WIDTH-1:0] IFID_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] IFID_instr_o,
    output logic                  IFID_valid_o,
    output logic [31:0]           Fetch_count_o,
    output logic [31:0]           Bubble_count_o
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(32'd4);

    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pc_plus4_s;
    logic [DATA_WIDTH-1:0] pc_next_s;
    logic [DATA_WIDTH-1:0] redirect_pc_s;
    logic                  load_s;
    if_id_t                ifid_d_s;
    if_id_t                ifid_q_s;

    // Wraps silently at 2^DATA_WIDTH.
    assign pc_plus4_s    = pc_r + PC_STEP;
    assign redirect_pc_s = {Redirect_target_i[DATA_WIDTH-1:2], 2'b00};

    // A genuine fetch happens only when neither a redirect nor a stall is active.
    assign load_s = ~Redirect_i & ~Stall_i;

    // Next-PC mux: redirect > stall > sequential.
    always_comb begin
        pc_next_s = pc_r;
        if (Redirect_i) begin
            pc_next_s = redirect_pc_s;
        end else if (Stall_i) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Program memory sees the PC register directly.
    assign Imem_addr_o = pc_r;

    // Bundle describing the instruction currently being fetched.
    always_comb begin
        ifid_d_s          = if_id_bubble();
        ifid_d_s.pc       = pc_r;
        ifid_d_s.pc_plus4 = pc_plus4_s;
        ifid_d_s.instr    = Imem_instr_i;
        ifid_d_s.valid    = 1'b1;
    end

    if_id_register u_if_id_register (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .flush (Redirect_i),
        .stall (Stall_i),
        .d     (ifid_d_s),
        .q     (ifid_q_s)
    );

    assign IFID_pc_o       = ifid_q_s.pc;
    assign IFID_pc_plus4_o = ifid_q_s.pc_plus4;
    assign IFID_instr_o    = ifid_q_s.instr;
    assign IFID_valid_o    = ifid_q_s.valid;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_r;
    logic [31:0] bubble_count_r;

    // Count valid loads and redirect bubbles; stall edges touch neither.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_r  <= 32'h0000_0000;
            bubble_count_r <= 32'h0000_0000;
        end else if (Redirect_i) begin
            bubble_count_r <= bubble_count_r + 32'h0000_0001;
        end else if (load_s) begin
            fetch_count_r  <= fetch_count_r + 32'h0000_0001;
        end else begin
            fetch_count_r  <= fetch_count_r;
            bubble_count_r <= bubble_count_r;
        end
    end

    assign Fetch_count_o  = fetch_count_r;
    assign Bubble_count_o = bubble_count_r;
`else
    assign Fetch_count_o  = 32'h0000_0000;
    assign Bubble_count_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage. Each stimulus row drives the
// inputs for one rising edge and queues the state expected after that edge;
// a separate monitor pops and compares shortly after every rising edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall_i = 1'b0;
    logic        Redirect_i = 1'b0;
    logic [31:0] Redirect_target_i = 32'h0000_0000;
    logic [31:0] Imem_addr_o;
    logic [31:0] Imem_instr_i;
    logic [31:0] IFID_pc_o;
    logic [31:0] IFID_pc_plus4_o;
    logic [31:0] IFID_instr_o;
    logic        IFID_valid_o;
    logic [31:0] Fetch_count_o;
    logic [31:0] Bubble_count_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ip4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] bc;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    // Program image: addi x1, x0, addr[11:0] at every word address.
    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[11:0], 20'h00093};
    endfunction

    assign Imem_instr_i = img(Imem_addr_o);

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .Stall_i           (Stall_i),
        .Redirect_i        (Redirect_i),
        .Redirect_target_i (Redirect_target_i),
        .Imem_addr_o       (Imem_addr_o),
        .Imem_instr_i      (Imem_instr_i),
        .IFID_pc_o         (IFID_pc_o),
        .IFID_pc_plus4_o   (IFID_pc_plus4_o),
        .IFID_instr_o      (IFID_instr_o),
        .IFID_valid_o      (IFID_valid_o),
        .Fetch_count_o     (Fetch_count_o),
        .Bubble_count_o    (Bubble_count_o)
    );

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    // One stimulus row: inputs for the next edge and hand-computed results.
    task automatic row(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt,
                       input logic [31:0] pc, input logic [31:0] ipc, input logic v,
                       input logic [31:0] fc, input logic [31:0] bc);
        exp_t e;
        @(negedge clk);
        reset = rst;
        Stall_i = stl;
        Redirect_i = rdr;
        Redirect_target_i = tgt;
        e.pc    = pc;
        e.ipc   = ipc;
        e.valid = v;
        e.ip4   = v ? ipc + 32'd4 : 32'h0000_0000;
        e.instr = v ? img(ipc) : 32'h0000_0013;
`ifdef FETCH_PERF_EN
        e.fc = fc;
        e.bc = bc;
`else
        e.fc = 32'h0000_0000;
        e.bc = 32'h0000_0000;
`endif
        sb_q.push_back(e);
    endtask

    // Monitor: compare DUT state just after each rising edge.
    initial begin : monitor
        int n;
        exp_t e;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("imem_addr", n, Imem_addr_o, e.pc);
                check("ifid_pc", n, IFID_pc_o, e.ipc);
                check("ifid_pc_plus4", n, IFID_pc_plus4_o, e.ip4);
                check("ifid_instr", n, IFID_instr_o, e.instr);
                check("ifid_valid", n, {31'd0, IFID_valid_o}, {31'd0, e.valid});
                check("fetch_count", n, Fetch_count_o, e.fc);
                check("bubble_count", n, Bubble_count_o, e.bc);
                n++;
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        //   rst   stl   rdr   target          pc             ifid_pc        v     fc  bc
        row(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0000, 32'h0000_0000, 1'b0, 32'd0, 32'd0);
        row(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0000, 32'h0000_0000, 1'b0, 32'd0, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0004, 32'h0040_0000, 1'b1, 32'd1, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_0004, 1'b1, 32'd2, 32'd0);
        // three stall edges at PC=0x0040_0008
        row(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_0004, 1'b1, 32'd2, 32'd0);
        row(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_0004, 1'b1, 32'd2, 32'd0);
        row(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_0004, 1'b1, 32'd2, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_000C, 32'h0040_0008, 1'b1, 32'd3, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0010, 32'h0040_000C, 1'b1, 32'd4, 32'd0);
        // redirect at PC=0x0040_0010 to 0x0040_0040
        row(1'b0, 1'b0, 1'b1, 32'h0040_0040, 32'h0040_0040, 32'h0000_0000, 1'b0, 32'd4, 32'd1);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0044, 32'h0040_0040, 1'b1, 32'd5, 32'd1);
        // redirect with stall, misaligned target
        row(1'b0, 1'b1, 1'b1, 32'h0040_0023, 32'h0040_0020, 32'h0000_0000, 1'b0, 32'd5, 32'd2);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0024, 32'h0040_0020, 1'b1, 32'd6, 32'd2);
        // reset together with stall and redirect
        row(1'b1, 1'b1, 1'b1, 32'h0040_0080, 32'h0040_0000, 32'h0000_0000, 1'b0, 32'd0, 32'd0);
        // counter run: 10 fetches, 2 redirects, 3 stalls; includes PC wrap
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0004, 32'h0040_0000, 1'b1, 32'd1, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_0004, 1'b1, 32'd2, 32'd0);
        row(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_0004, 1'b1, 32'd2, 32'd0);
        row(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_0004, 1'b1, 32'd2, 32'd0);
        row(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0040_0008, 32'h0040_0004, 1'b1, 32'd2, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_000C, 32'h0040_0008, 1'b1, 32'd3, 32'd0);
        row(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'd3, 32'd1);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 32'd4, 32'd1);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 1'b1, 32'd5, 32'd1);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_0004, 1'b1, 32'd6, 32'd1);
        row(1'b0, 1'b0, 1'b1, 32'h0040_0101, 32'h0040_0100, 32'h0000_0000, 1'b0, 32'd6, 32'd2);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0104, 32'h0040_0100, 1'b1, 32'd7, 32'd2);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0108, 32'h0040_0104, 1'b1, 32'd8, 32'd2);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_010C, 32'h0040_0108, 1'b1, 32'd9, 32'd2);
        row(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0040_0110, 32'h0040_010C, 1'b1, 32'd10, 32'd2);
        // drain the scoreboard with a bounded wait
        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
